// File: rtl/secventiator_intersectie_if.sv
// Handshake bundle between the intersection sequencer, the car-light stage and the pedestrian lamps.
interface secventiator_intersectie_if;
    logic       service_i;
    logic       buton_pieton_i;
    logic       auto_done_i;
    logic       auto_enable_o;
    logic       auto_clear_o;
    logic       pieton_verde_o;
    logic       pieton_rosu_o;
    logic       cerere_activa_o;
    logic [1:0] faza_o;

    modport slave (
        input  service_i,
        input  buton_pieton_i,
        input  auto_done_i,
        output auto_enable_o,
        output auto_clear_o,
        output pieton_verde_o,
        output pieton_rosu_o,
        output cerere_activa_o,
        output faza_o
    );

    modport master (
        output service_i,
        output buton_pieton_i,
        output auto_done_i,
        input  auto_enable_o,
        input  auto_clear_o,
        input  pieton_verde_o,
        input  pieton_rosu_o,
        input  cerere_activa_o,
        input  faza_o
    );
endinterface

// File: rtl/secventiator_intersectie.sv
// Intersection sequencer: alternates car-light stage and pedestrian crossing, with a service override.
// Optional macro CLIPIRE_PIETON_EN blinks the pedestrian green during the last 2 seconds.
module secventiator_intersectie #(
    parameter int unsigned SEC_PIETON = 8,
    parameter int unsigned FACTOR_DIV = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_n,
    secventiator_intersectie_if.slave    bus
);

    localparam int unsigned PW = (FACTOR_DIV > 1) ? $clog2(FACTOR_DIV) : 1;
    localparam int unsigned SW = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AUTO    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_PIETON  = 3'd3,
        ST_TAMPON  = 3'd4,
        ST_SERVICE = 3'd5
    } stare_t;

    stare_t          state_q, state_nxt;
    logic [PW-1:0]   presc_q, presc_nxt;
    logic [SW-1:0]   sec_q, sec_nxt;
    logic            latch_q, latch_nxt;
    logic            tick;

    logic            en_q, clr_q, verde_q, rosu_q;
    logic [1:0]      faza_q;
    logic            en_d, clr_d, verde_d, rosu_d;
    logic [1:0]      faza_d;

    assign tick = (presc_q == PW'(FACTOR_DIV - 1));

    // Next state, counters and request latch
    always_comb begin
        state_nxt = state_q;
        presc_nxt = tick ? '0 : presc_q + PW'(1);
        sec_nxt   = sec_q;
        latch_nxt = latch_q;

        if (bus.service_i) begin
            state_nxt = ST_SERVICE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_nxt = ST_AUTO;
                ST_AUTO:    if (bus.auto_done_i) state_nxt = ST_CLEAR;
                ST_CLEAR:   state_nxt = (latch_q || bus.buton_pieton_i) ? ST_PIETON : ST_AUTO;
                ST_PIETON:  if (tick && (sec_q == SW'(SEC_PIETON - 1))) state_nxt = ST_TAMPON;
                ST_TAMPON:  if (tick) state_nxt = ST_AUTO;
                ST_SERVICE: state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end

        if (bus.buton_pieton_i &&
            (state_q == ST_IDLE || state_q == ST_AUTO || state_q == ST_CLEAR)) begin
            latch_nxt = 1'b1;
        end

        if (state_q == ST_PIETON && tick) begin
            sec_nxt = sec_q + SW'(1);
        end

        // Phase entry reloads timing; service parks everything at zero
        if (state_nxt != state_q && (state_nxt == ST_PIETON || state_nxt == ST_TAMPON)) begin
            presc_nxt = '0;
        end
        if (state_nxt == ST_PIETON && state_q != ST_PIETON) begin
            sec_nxt   = '0;
            latch_nxt = 1'b0;
        end
        if (state_nxt == ST_SERVICE) begin
            presc_nxt = '0;
            sec_nxt   = '0;
            latch_nxt = 1'b0;
        end
    end

    // Output decode of the upcoming registered state, so outputs are flops aligned with state_q
    always_comb begin
        en_d    = 1'b0;
        clr_d   = 1'b0;
        verde_d = 1'b0;
        rosu_d  = 1'b1;
        faza_d  = 2'd0;
        unique case (state_nxt)
            ST_IDLE: begin
                faza_d = 2'd0;
            end
            ST_AUTO: begin
                en_d   = 1'b1;
                faza_d = 2'd1;
            end
            ST_CLEAR: begin
                clr_d  = 1'b1;
                faza_d = 2'd3;
            end
            ST_PIETON: begin
                rosu_d = 1'b0;
                faza_d = 2'd2;
`ifdef CLIPIRE_PIETON_EN
                if (sec_nxt >= SW'(SEC_PIETON - 2)) begin
                    verde_d = (presc_nxt < PW'(FACTOR_DIV / 2));
                end else begin
                    verde_d = 1'b1;
                end
`else
                verde_d = 1'b1;
`endif
            end
            ST_TAMPON: begin
                faza_d = 2'd3;
            end
            ST_SERVICE: begin
                clr_d  = 1'b1;
                rosu_d = 1'b0;
                faza_d = 2'd0;
            end
            default: begin
                faza_d = 2'd0;
            end
        endcase
    end

    // State, counters, latch and registered outputs
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            sec_q   <= '0;
            latch_q <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            verde_q <= 1'b0;
            rosu_q  <= 1'b1;
            faza_q  <= 2'd0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            sec_q   <= sec_nxt;
            latch_q <= latch_nxt;
            en_q    <= en_d;
            clr_q   <= clr_d;
            verde_q <= verde_d;
            rosu_q  <= rosu_d;
            faza_q  <= faza_d;
        end
    end

    assign bus.auto_enable_o   = en_q;
    assign bus.auto_clear_o    = clr_q;
    assign bus.pieton_verde_o  = verde_q;
    assign bus.pieton_rosu_o   = rosu_q;
    assign bus.cerere_activa_o = latch_q;
    assign bus.faza_o          = faza_q;

endmodule

// File: tb/tb_secventiator_intersectie.sv
// Bench for secventiator_intersectie: phase/duration model compared every cycle plus literal pins.
module tb_secventiator_intersectie;

    localparam int unsigned F = 4;
    localparam int unsigned S = 3;

    localparam logic [2:0] M_IDLE = 3'd0, M_AUTO = 3'd1, M_CLEAR = 3'd2,
                           M_PIET = 3'd3, M_TAMP = 3'd4, M_SVC  = 3'd5;

    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] left;
        logic [15:0] el;
        logic        req;
    } mdl_t;

    logic clk_i = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    mdl_t m;

    secventiator_intersectie_if bus();

    secventiator_intersectie #(.SEC_PIETON(S), .FACTOR_DIV(F)) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Model: phase plus remaining cycles, driven from the rules rather than counters/ticks
    function automatic mdl_t m_next(input mdl_t c, input logic svc, input logic btn, input logic done);
        mdl_t n = c;
        if (btn && (c.ph == M_IDLE || c.ph == M_AUTO || c.ph == M_CLEAR)) n.req = 1'b1;
        if (svc) begin
            n.ph  = M_SVC;
            n.req = 1'b0;
        end else begin
            case (c.ph)
                M_IDLE: n.ph = M_AUTO;
                M_AUTO: if (done) n.ph = M_CLEAR;
                M_CLEAR: begin
                    if (c.req || btn) begin
                        n.ph   = M_PIET;
                        n.left = 16'(S * F);
                        n.el   = 16'd0;
                        n.req  = 1'b0;
                    end else begin
                        n.ph = M_AUTO;
                    end
                end
                M_PIET: begin
                    n.el = c.el + 16'd1;
                    if (c.left == 16'd1) begin
                        n.ph   = M_TAMP;
                        n.left = 16'(F);
                    end else begin
                        n.left = c.left - 16'd1;
                    end
                end
                M_TAMP: begin
                    if (c.left == 16'd1) n.ph = M_AUTO;
                    else n.left = c.left - 16'd1;
                end
                default: n.ph = M_IDLE;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) m <= '{ph: M_IDLE, left: 16'd0, el: 16'd0, req: 1'b0};
        else m <= m_next(m, bus.service_i, bus.buton_pieton_i, bus.auto_done_i);
    end

    function automatic logic e_verde(input mdl_t c);
        if (c.ph != M_PIET) return 1'b0;
`ifdef CLIPIRE_PIETON_EN
        if (int'(c.el) >= int'((S - 2) * F) && (int'(c.el) % int'(F)) >= int'(F / 2)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [1:0] e_faza(input mdl_t c);
        case (c.ph)
            M_AUTO:         return 2'd1;
            M_PIET:         return 2'd2;
            M_CLEAR, M_TAMP: return 2'd3;
            default:        return 2'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("auto_enable",  32'(bus.auto_enable_o),   32'(m.ph == M_AUTO));
        chk("auto_clear",   32'(bus.auto_clear_o),    32'(m.ph == M_CLEAR || m.ph == M_SVC));
        chk("pieton_verde", 32'(bus.pieton_verde_o),  32'(e_verde(m)));
        chk("pieton_rosu",  32'(bus.pieton_rosu_o),   32'(!(m.ph == M_PIET || m.ph == M_SVC)));
        chk("cerere",       32'(bus.cerere_activa_o), 32'(m.req));
        chk("faza",         32'(bus.faza_o),          32'(e_faza(m)));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            compare();
        end
    endtask

    task automatic wait_faza(input logic [1:0] f, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.faza_o == f) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk("wait_faza_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse(input int which);
        if (which == 0) bus.buton_pieton_i = 1'b1;
        else bus.auto_done_i = 1'b1;
        step(1);
        bus.buton_pieton_i = 1'b0;
        bus.auto_done_i    = 1'b0;
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] exp_pat;
        int          pc;
        int          tc;

`ifdef CLIPIRE_PIETON_EN
        exp_pat = 12'b1111_1100_1100;
`else
        exp_pat = 12'b1111_1111_1111;
`endif
        bus.service_i      = 1'b0;
        bus.buton_pieton_i = 1'b0;
        bus.auto_done_i    = 1'b0;
        reset_n            = 1'b1;
        #1 reset_n = 1'b0;

        step(2);
        chk("rst_faza", 32'(bus.faza_o), 32'd0);
        chk("rst_rosu", 32'(bus.pieton_rosu_o), 32'd1);
        reset_n = 1'b1;
        step(1);
        chk("first_auto", 32'(bus.faza_o), 32'd1);

        // Plain car cycle, no request
        step(3);
        pulse(1);
        chk("clear_pulse", 32'(bus.auto_clear_o), 32'd1);
        step(1);
        chk("back_auto", 32'(bus.faza_o), 32'd1);
        chk("rosu_auto", 32'(bus.pieton_rosu_o), 32'd1);

        // Pedestrian request served
        pulse(0);
        chk("req_latched", 32'(bus.cerere_activa_o), 32'd1);
        step(2);
        pulse(1);
        chk("clear_faza", 32'(bus.faza_o), 32'd3);
        pat = '0;
        pc  = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            pat[11 - i] = bus.pieton_verde_o;
            if (bus.faza_o == 2'd2) pc++;
        end
        chk("verde_pattern", 32'(pat), 32'(exp_pat));
        chk("pieton_len", 32'(pc), 32'd12);
        tc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.faza_o != 2'd3) break;
            tc++;
        end
        chk("tampon_len", 32'(tc), 32'd4);
        chk("after_tampon", 32'(bus.faza_o), 32'd1);
        chk("req_cleared", 32'(bus.cerere_activa_o), 32'd0);

        // Button ignored during PIETON and TAMPON
        pulse(0);
        pulse(1);
        wait_faza(2'd2, 5);
        step(2);
        pulse(0);
        chk("ign_pieton", 32'(bus.cerere_activa_o), 32'd0);
        wait_faza(2'd3, 20);
        pulse(0);
        chk("ign_tampon", 32'(bus.cerere_activa_o), 32'd0);
        wait_faza(2'd1, 10);
        pulse(1);
        chk("clear_no_req", 32'(bus.faza_o), 32'd3);
        step(1);
        chk("auto_no_req", 32'(bus.faza_o), 32'd1);

        // Service mid-PIETON; auto_done ignored outside AUTO
        pulse(0);
        pulse(1);
        wait_faza(2'd2, 5);
        bus.auto_done_i = 1'b1;
        step(2);
        bus.auto_done_i = 1'b0;
        chk("done_ignored", 32'(bus.faza_o), 32'd2);
        bus.service_i = 1'b1;
        step(1);
        chk("svc_verde", 32'(bus.pieton_verde_o), 32'd0);
        chk("svc_rosu", 32'(bus.pieton_rosu_o), 32'd0);
        chk("svc_clear", 32'(bus.auto_clear_o), 32'd1);
        step(4);
        bus.service_i = 1'b0;
        step(1);
        chk("svc_idle", 32'(bus.faza_o), 32'd0);
        chk("svc_idle_rosu", 32'(bus.pieton_rosu_o), 32'd1);
        step(1);
        chk("svc_auto", 32'(bus.faza_o), 32'd1);

        // Asynchronous reset mid-PIETON
        pulse(0);
        pulse(1);
        wait_faza(2'd2, 5);
        step(5);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_verde", 32'(bus.pieton_verde_o), 32'd0);
        chk("arst_rosu", 32'(bus.pieton_rosu_o), 32'd1);
        chk("arst_faza", 32'(bus.faza_o), 32'd0);
        chk("arst_en", 32'(bus.auto_enable_o), 32'd0);
        chk("arst_clr", 32'(bus.auto_clear_o), 32'd0);
        chk("arst_req", 32'(bus.cerere_activa_o), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("arst_auto", 32'(bus.faza_o), 32'd1);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secventiator_intersectie.md
SECVENTIATOR_INTERSECTIE -- requirements
Module: secventiator_intersectie

Interface
REQ-001 SHALL have parameter SEC_PIETON, default 8, pedestrian-green duration in 1 s ticks, legal range 3..63.
REQ-002 SHALL have parameter FACTOR_DIV, default 10, clk_i cycles per 1 s tick, legal range 2..1023.
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port service_i  input  1  service mode request, level.
REQ-006 SHALL have port buton_pieton_i  input  1  pedestrian request, synchronous, any high cycle counts.
REQ-007 SHALL have port auto_done_i  input  1  car-light stage finished its cycle and holds red.
REQ-008 SHALL have port auto_enable_o  output  1  start/run enable to car-light stage.
REQ-009 SHALL have port auto_clear_o  output  1  return car-light stage to idle.
REQ-010 SHALL have port pieton_verde_o  output  1  pedestrian green lamp.
REQ-011 SHALL have port pieton_rosu_o  output  1  pedestrian red lamp.
REQ-012 SHALL have port cerere_activa_o  output  1  pedestrian request latched, pending.
REQ-013 SHALL have port faza_o  output  2  phase: 0 IDLE/SERVICE, 1 AUTO, 2 PIETON, 3 CLEAR/TAMPON.

Function
REQ-014 SHALL implement states IDLE, AUTO, CLEAR, PIETON, TAMPON, SERVICE, registered, with combinational next-state.
REQ-015 IDLE SHALL go to AUTO on the next clock when service_i=0.
REQ-016 AUTO SHALL drive auto_enable_o=1 and stay until auto_done_i=1, then go to CLEAR.
REQ-017 CLEAR SHALL last exactly one cycle with auto_clear_o=1, auto_enable_o=0, then go to PIETON if request latched, else AUTO.
REQ-018 PIETON SHALL drive pieton_verde_o=1, pieton_rosu_o=0 for exactly SEC_PIETON*FACTOR_DIV cycles, then go to TAMPON.
REQ-019 TAMPON SHALL drive both car enable and pedestrian green low, pieton_rosu_o=1, for exactly FACTOR_DIV cycles, then go to AUTO.
REQ-020 In all states except PIETON and SERVICE, pieton_rosu_o SHALL be 1 and pieton_verde_o 0.
REQ-021 Tick prescaler SHALL count 0..FACTOR_DIV-1, emit 1-cycle tick at FACTOR_DIV-1, wrap to 0, and reload 0 on entry to PIETON and TAMPON.
REQ-022 Seconds counter (6 bit) SHALL clear on PIETON entry, increment per tick, PIETON exits on tick when counter==SEC_PIETON-1.
REQ-023 Request latch SHALL set on buton_pieton_i=1 in IDLE, AUTO or CLEAR; ignored in PIETON, TAMPON, SERVICE.
REQ-024 Request latch SHALL clear on PIETON entry; button high in the same CLEAR cycle still counts as latched for that transition.
REQ-025 cerere_activa_o SHALL equal the latch register, no combinational path from buton_pieton_i.
REQ-026 service_i=1 SHALL force SERVICE from any state on the next clock, overriding all other transitions.
REQ-027 SERVICE SHALL drive auto_enable_o=0, auto_clear_o=1, both pedestrian lamps 0, latch cleared, prescaler held at 0.
REQ-028 SERVICE SHALL go to IDLE on the first clock with service_i=0.
REQ-029 auto_done_i=1 outside AUTO SHALL be ignored.
REQ-030 All outputs SHALL be decoded from registered state/counters only.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, prescaler 0, seconds counter 0, latch 0.
REQ-032 During and after reset, until leaving IDLE: auto_enable_o=0, auto_clear_o=0, pieton_verde_o=0, pieton_rosu_o=1, cerere_activa_o=0, faza_o=0.
REQ-033 Reset asserted mid-PIETON SHALL abort the phase; first AUTO follows one cycle after release.

Configuration
REQ-034 Macro CLIPIRE_PIETON_EN defined: during the last 2 seconds of PIETON (counter>=SEC_PIETON-2), pieton_verde_o SHALL be 1 while prescaler<FACTOR_DIV/2, else 0; pieton_rosu_o stays 0.
REQ-035 Macro CLIPIRE_PIETON_EN undefined: pieton_verde_o SHALL be steady 1 for the whole PIETON phase; no blink logic synthesized.

Verification (FACTOR_DIV=4, SEC_PIETON=3)
REQ-036 Reset release, no button -> cycle 1 AUTO; auto_done_i pulse -> one-cycle auto_clear_o, back to AUTO, pieton_rosu_o=1 throughout.
REQ-037 Button pulse in AUTO, then auto_done_i -> cerere_activa_o=1 next cycle, CLEAR 1 cycle, pieton_verde_o=1 for 12 cycles, TAMPON 4 cycles, AUTO, cerere_activa_o=0.
REQ-038 Button pulses during PIETON and TAMPON -> cerere_activa_o stays 0; next auto_done_i returns to AUTO via CLEAR.
REQ-039 service_i=1 mid-PIETON for 5 cycles -> next cycle all lamps 0, auto_clear_o=1; release -> IDLE then AUTO.
REQ-040 With CLIPIRE_PIETON_EN: pieton_verde_o pattern over 12 PIETON cycles = 1111 1100 1100.
REQ-041 reset_n low mid-PIETON asynchronously -> outputs at REQ-032 values before the next clock edge.
